// File: rtl/serial_adder16.sv
// Bit-serial add/subtract: one full_adder cell is fed one bit slice per clock,
// LSB first, and the result is reassembled into a WIDTH-bit sum with flags.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic fa_sum, fa_carry;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (cin_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cin_d    = cin_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_sh_d  = A;
          b_sh_d  = sub ? ~B : B;
          cin_d   = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        cin_d    = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // cin_q here is the carry into the MSB slice.
          sum_d   = {fa_sum, res_sh_q[WIDTH-1:1]};
          carry_d = fa_carry;
          ovf_d   = cin_q ^ fa_carry;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cin_q    <= cin_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder16.sv
// Bench for serial_adder16: arithmetic/latency model checked every cycle,
// plus hand-computed results checked at each done pulse.

module tb_serial_adder16;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          busy, done, carry, overflow;
  logic [W-1:0]  sum;

  serial_adder16 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model: m_t counts edges since the accepting edge (0 = nothing in flight).
  int           m_t = 0;
  logic [W-1:0] p_sum = '0, e_sum = '0;
  logic         p_c = 1'b0, p_v = 1'b0, e_c = 1'b0, e_v = 1'b0;

  function automatic logic [W+1:0] arith(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    full = s ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
    r    = full[W-1:0];
    if (s) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else   v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {r, full[W], v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; e_sum <= '0; e_c <= 1'b0; e_v <= 1'b0;
    end else begin
      if ((m_t == 0 || m_t == W + 1) && start) begin
        m_t <= 1;
        {p_sum, p_c, p_v} <= arith(A, B, sub);
      end else if (m_t == W + 1) m_t <= 0;
      else if (m_t != 0)         m_t <= m_t + 1;
      if (m_t == W) begin
        e_sum <= p_sum; e_c <= p_c; e_v <= p_v;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [W+1:0] lit_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W+1:0] lit;
    chk("busy", W'(busy), W'(m_t >= 1 && m_t <= W));
    chk("done", W'(done), W'(m_t == W + 1));
    chk("sum", sum, e_sum);
    chk("carry", W'(carry), W'(e_c));
    chk("overflow", W'(overflow), W'(e_v));
    if (m_t == W + 1) begin
      if (lit_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL lit_queue at %0t: got done with no expected result queued", $time);
      end else begin
        lit = lit_q.pop_front();
        chk("lit_sum", sum, lit[W+1:2]);
        chk("lit_carry", W'(carry), W'(lit[1]));
        chk("lit_ovf", W'(overflow), W'(lit[0]));
      end
    end
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(posedge clk); #1;
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic [W-1:0] es, input logic ec, input logic ev);
    lit_q.push_back({es, ec, ev});
    go(a, b, s);
    repeat (W + 2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op(16'h1234, 16'h4321, 1'b1, 16'hCF13, 1'b0, 1'b0);

    // Start during RUN must be ignored.
    lit_q.push_back({16'h2345, 1'b0, 1'b0});
    go(16'h1234, 16'h1111, 1'b0);
    repeat (4) @(posedge clk);
    #1 A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (W) @(posedge clk);

    // Asynchronous reset mid-RUN discards the operation.
    go(16'h00FF, 16'h0001, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 8) @(posedge clk);

    // Back-to-back with start held high; operands change in the DONE cycle.
    @(posedge clk); #1;
    A = 16'h0003; B = 16'h0004; sub = 1'b0; start = 1'b1;
    lit_q.push_back({16'h0007, 1'b0, 1'b0});
    @(posedge clk);
    repeat (W) @(posedge clk);
    #1 A = 16'h0010; B = 16'h0001; sub = 1'b1;
    lit_q.push_back({16'h000F, 1'b1, 1'b0});
    @(posedge clk);
    repeat (W) @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder16.md
# serial_adder16

Bit-serial add/subtract unit that feeds the existing one-bit `full_adder` cell one bit slice per clock, LSB first, and reassembles its `sum`/`carry` outputs into a 16-bit result with carry and signed-overflow flags. It sits in the execute stage beside the parallel ALU. It serves as the low-area arithmetic path for multi-cycle instructions, and as a structural check of the `full_adder` cell inside a clocked datapath. A start/busy/done handshake frames each operation.

## Interface
- `WIDTH`, 16, operand and result width in bits (≥2).
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; sampled on `clk` only in IDLE or DONE.
- `sub`  in  1  0 = A+B, 1 = A−B; sampled with `start`.
- `A`  in  WIDTH  operand A; sampled with `start`.
- `B`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  single-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result; holds until the next completion.
- `carry`  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement overflow.

## Operation
- One `full_adder` instance, driven each cycle by these inputs:
  - operand-A shift register bit 0;
  - operand-B shift register bit 0 (B is inverted at load when `sub`=1);
  - a carry flip-flop (`Cin`).
- FSM states: IDLE, RUN, DONE. A `$clog2(WIDTH)`-bit bit counter runs alongside.
- IDLE/DONE with `start`=1 at an edge:
  - load A, and B or ~B;
  - set carry FF = `sub`;
  - clear the counter;
  - go to RUN.
- IDLE/DONE with `start`=0: DONE → IDLE; IDLE stays IDLE.
- RUN, every edge:
  - shift both operand registers right one bit;
  - shift the `full_adder` `sum` bit into the MSB of the internal result shift register;
  - carry FF ← `full_adder` `carry`;
  - increment the counter.
- RUN, final edge (counter = WIDTH−1):
  - copy the complete result into `sum`;
  - `carry` ← full_adder carry;
  - `overflow` ← (carry FF value before this edge, i.e. carry into MSB) XOR (full_adder carry);
  - go to DONE.
- `start` during RUN is ignored; operands are not re-sampled.
- Arithmetic is modulo 2^WIDTH. `sub` uses A + ~B + 1.

## Timing
- Reset (`rst_n`=0, any time, including mid-RUN):
  - state IDLE; counter 0;
  - `busy`=0, `done`=0, `sum`=0, `carry`=0, `overflow`=0;
  - internal shift registers and carry FF cleared;
  - any in-flight operation is discarded. On release, the block waits for a new `start`.
- `busy` = (state == RUN); `done` = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- Cycle timeline, with start accepted at edge E0:
  - `busy` rises after E0;
  - bit i is processed at edge E(i+1);
  - after E(WIDTH), `busy`=0, `done`=1, and `sum`/`carry`/`overflow` are updated;
  - after E(WIDTH+1), `done`=0.
- Latency: WIDTH+1 edges from accept to the `done` pulse, i.e. 17 for WIDTH=16.
- Back-to-back: `start`=1 during the DONE cycle is accepted. RUN resumes with no idle gap, so throughput is one op per WIDTH+1 cycles.
- `sum`, `carry` and `overflow` change only on the final RUN edge or on reset. They are stable during RUN of the next operation.

## Test plan
- Reset, then A=0x0001, B=0x0001, `sub`=0, `start` for 1 cycle:
  - `busy` high for exactly 16 cycles;
  - `done` pulses on cycle 17 after the accept edge;
  - `sum`=0x0002, `carry`=0, `overflow`=0.
- Add boundaries:
  - 0xFFFF+0x0001 → `sum`=0x0000, `carry`=1, `overflow`=0;
  - 0x7FFF+0x0001 → `sum`=0x8000, `carry`=0, `overflow`=1.
- Subtract:
  - 0x0005−0x0007 → `sum`=0xFFFE, `carry`=0, `overflow`=0;
  - 0x8000−0x0001 → `sum`=0x7FFF, `carry`=1, `overflow`=1.
- Start 0x1234+0x1111, then pulse `start` with A=0xFFFF, B=0xFFFF at RUN cycle 5:
  - the second start is ignored;
  - `sum`=0x2345, delivered at the normal `done` time.
- Start 0x00FF+0x0001, assert `rst_n`=0 asynchronously mid-cycle at RUN cycle 8:
  - all outputs go to 0 immediately;
  - after release with no `start`, `done` never pulses.
- Hold `start`=1 continuously with 0x0003+0x0004, then 0x0010−0x0001, changing operands in the DONE cycle:
  - `done` pulses every 17 cycles;
  - `sum`=0x0007, then 0x000F.
